// File: rtl/uart_pkg.sv
// Purpose : shared UART definitions (baud-select codes, arbiter FSM states, index-width helper).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Reference system clock assumed by the UART baud generators.
    localparam int CLK_IN = 50_000_000;

    // Two-bit baud select codes, common to the RX and TX datapaths.
    localparam logic [1:0] BPS_9600   = 2'b00;
    localparam logic [1:0] BPS_19200  = 2'b01;
    localparam logic [1:0] BPS_38400  = 2'b10;
    localparam logic [1:0] BPS_921600 = 2'b11;

    // TX arbiter sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LAUNCH,
        WAIT_DONE,
        GAP
    } arb_state_t;

    // Width of an index into n requesters, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Purpose : requester-side and transmitter-side signals of the shared UART TX arbiter.
// Latency : n/a (wiring only).
// Backpressure: requesters hold req until grant; the transmitter paces frames via tx_done.
// Ports   : slave = arbiter view, master = requester/transmitter environment view.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) ();

    logic [N_REQ-1:0]         req;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ*2-1:0]       req_bps;
    logic [N_REQ-1:0]         grant;
    logic                     tx_start;
    logic [DATA_W-1:0]        tx_data;
    logic [1:0]               bps_set;
    logic                     tx_done;
    logic                     busy;
    logic [idx_w(N_REQ)-1:0]  owner;
    logic                     err;

    modport slave (
        input  req, req_data, req_bps, tx_done,
        output grant, tx_start, tx_data, bps_set, busy, owner, err
    );

    modport master (
        output req, req_data, req_bps, tx_done,
        input  grant, tx_start, tx_data, bps_set, busy, owner, err
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Purpose : combinational round-robin picker; searches last+1, last+2, ... modulo N_REQ.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; vld is simply low when no request is asserted.
// Ports   : req (request vector), last (previous winner) -> vld, idx (winner index).
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW   = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             vld,
    output logic [IW-1:0]    idx
);

    int cand;

    // Walk the search order from the far end so the nearest asserted
    // requester after 'last' is the final (winning) assignment.
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = (int'(last) + k) % N_REQ;
            if (req[cand]) begin
                vld = 1'b1;
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Purpose : round-robin arbiter/sequencer sharing one UART TX among N_REQ byte requesters.
// Latency : req seen in IDLE at T -> grant at T+1 -> tx_start at T+2; next arbitration GAP_CYC+1 after tx_done.
// Backpressure: requesters hold req until granted; frames are paced by tx_done plus the inter-frame gap.
// Ports   : clk, rst (async, active-high), bus (uart_tx_arb_if.slave: req/req_data/req_bps/grant,
//           tx_start/tx_data/bps_set/tx_done, busy/owner/err).
// Option  : UART_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog of TIMEOUT_CYC cycles driving err.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_arb_if.slave  bus
);

    localparam int IW = idx_w(N_REQ);
    localparam int GW = $clog2(GAP_CYC + 2);

    arb_state_t         state, state_nxt;
    logic [IW-1:0]      last;
    logic [IW-1:0]      owner_q;
    logic [DATA_W-1:0]  data_q;
    logic [1:0]         bps_q;
    logic [GW-1:0]      gap_cnt;
    logic               pick_vld;
    logic [IW-1:0]      pick_idx;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (bus.req),
        .last (last),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_comb begin
        state_nxt = state;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        case (state)
            IDLE:      if (pick_vld) state_nxt = GRANT;
            GRANT:     state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (bus.tx_done) begin
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
                end
`endif
            end
            GAP:       if (gap_cnt == GW'(GAP_CYC - 1)) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= IW'(N_REQ - 1);
            owner_q <= '0;
            data_q  <= '0;
            bps_q   <= BPS_9600;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Byte and baud are latched at the pick so bps_set settles a cycle before tx_start.
            if (state == IDLE && pick_vld) begin
                owner_q <= pick_idx;
                data_q  <= bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
                bps_q   <= bus.req_bps[int'(pick_idx)*2 +: 2];
            end
            if (state == GRANT) begin
                last <= owner_q;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT_DONE) ? tmo_cnt + 1'b1 : '0;
            err_q   <= tmo_hit;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.grant    = (state == GRANT) ? (N_REQ'(1) << owner_q) : '0;
    assign bus.tx_start = (state == LAUNCH);
    assign bus.busy     = (state != IDLE);
    assign bus.owner    = owner_q;
    assign bus.tx_data  = data_q;
    assign bus.bps_set  = bps_q;

endmodule
